// File: rtl/block_scan_serializer.sv
// rtl/block_scan_serializer.sv - buffers 8x8 blocks and streams them in progressive scan order; optional SCAN_SAT16_EN saturates output to 16 bits
module block_scan_serializer #(
    parameter int BUF_BLOCKS = 2
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               input_valid,
    output logic               input_ready,
    input  logic signed [31:0] INPUT_DATA [0:7][0:7],
    output logic               output_valid,
    input  logic               output_ready,
    output logic signed [31:0] OUTPUT_DATA,
    output logic [5:0]         output_index,
    output logic               output_last
);

    typedef enum logic {EMPTY, STREAM} state_t;

    localparam logic [1:0] MAX_BLOCKS = 2'(BUF_BLOCKS);

    state_t             state;
    logic [1:0]         count;
    logic               wr_ptr;
    logic               rd_ptr;
    logic signed [31:0] mem [0:1][0:7][0:7];

    logic               accept;
    logic               beat;
    logic               last_beat;
    logic [5:0]         next_pos;
    logic [5:0]         next_raster;

    // Progressive scan position -> raster index (row*8+col)
    function automatic logic [5:0] scan_raster(input logic [5:0] pos);
        logic [5:0] r;
        r = 6'd0;
        case (pos)
            6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd9;
            6'd4:  r = 6'd2;   6'd5:  r = 6'd3;   6'd6:  r = 6'd10;  6'd7:  r = 6'd11;
            6'd8:  r = 6'd16;  6'd9:  r = 6'd17;  6'd10: r = 6'd24;  6'd11: r = 6'd25;
            6'd12: r = 6'd18;  6'd13: r = 6'd19;  6'd14: r = 6'd26;  6'd15: r = 6'd27;
            6'd16: r = 6'd4;   6'd17: r = 6'd5;   6'd18: r = 6'd12;  6'd19: r = 6'd20;
            6'd20: r = 6'd13;  6'd21: r = 6'd6;   6'd22: r = 6'd7;   6'd23: r = 6'd14;
            6'd24: r = 6'd21;  6'd25: r = 6'd28;  6'd26: r = 6'd29;  6'd27: r = 6'd22;
            6'd28: r = 6'd15;  6'd29: r = 6'd23;  6'd30: r = 6'd30;  6'd31: r = 6'd31;
            6'd32: r = 6'd32;  6'd33: r = 6'd33;  6'd34: r = 6'd40;  6'd35: r = 6'd48;
            6'd36: r = 6'd41;  6'd37: r = 6'd34;  6'd38: r = 6'd35;  6'd39: r = 6'd42;
            6'd40: r = 6'd49;  6'd41: r = 6'd56;  6'd42: r = 6'd57;  6'd43: r = 6'd50;
            6'd44: r = 6'd43;  6'd45: r = 6'd36;  6'd46: r = 6'd37;  6'd47: r = 6'd44;
            6'd48: r = 6'd51;  6'd49: r = 6'd58;  6'd50: r = 6'd59;  6'd51: r = 6'd52;
            6'd52: r = 6'd45;  6'd53: r = 6'd38;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
            6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
            6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;  6'd63: r = 6'd63;
        endcase
        return r;
    endfunction

    // Output value shaping: optional clamp to the signed 16-bit range
    function automatic logic signed [31:0] out_value(input logic signed [31:0] v);
`ifdef SCAN_SAT16_EN
        if (v > 32'sd32767) begin
            return 32'sd32767;
        end else if (v < -32'sd32768) begin
            return -32'sd32768;
        end
        return v;
`else
        return v;
`endif
    endfunction

    assign accept       = input_valid && input_ready;
    assign beat         = output_valid && output_ready;
    assign last_beat    = beat && (output_index == 6'd63);
    assign next_pos     = output_index + 6'd1;
    assign next_raster  = scan_raster(next_pos);
    assign input_ready  = (count < MAX_BLOCKS);
    assign output_valid = (state == STREAM);

    // Block storage: a whole block lands in the write slot on accept
    always_ff @(posedge CLOCK) begin
        if (accept) begin
            mem[wr_ptr] <= INPUT_DATA;
        end
    end

    // Occupancy count and circular slot pointers; count includes the block being streamed
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (last_beat) begin
                rd_ptr <= ~rd_ptr;
            end
            if (accept && !last_beat) begin
                count <= count + 2'd1;
            end else if (!accept && last_beat) begin
                count <= count - 2'd1;
            end
        end
    end

    // Stream FSM with registered coefficient, index and last flag
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state        <= EMPTY;
            OUTPUT_DATA  <= '0;
            output_index <= '0;
            output_last  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        // Slot is written on this same edge, so take position 0 straight from the input
                        state        <= STREAM;
                        OUTPUT_DATA  <= out_value(INPUT_DATA[0][0]);
                        output_index <= 6'd0;
                        output_last  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (beat && !last_beat) begin
                        output_index <= next_pos;
                        output_last  <= (next_pos == 6'd63);
                        OUTPUT_DATA  <= out_value(mem[rd_ptr][next_raster[5:3]][next_raster[2:0]]);
                    end else if (last_beat) begin
                        output_index <= 6'd0;
                        output_last  <= 1'b0;
                        if (count == 2'd2) begin
                            // Next block already buffered in the other slot
                            OUTPUT_DATA <= out_value(mem[~rd_ptr][0][0]);
                        end else if (accept) begin
                            // Next block arrives on this very edge
                            OUTPUT_DATA <= out_value(INPUT_DATA[0][0]);
                        end else begin
                            state       <= EMPTY;
                            OUTPUT_DATA <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_scan_serializer.sv
// tb/tb_block_scan_serializer.sv - randomized self-checking bench against a queue-based scan model
module tb_block_scan_serializer;

    logic               CLOCK = 1'b0;
    logic               RESET = 1'b0;
    logic               input_valid = 1'b0;
    logic               output_ready = 1'b1;
    logic               input_ready;
    logic               output_valid;
    logic               output_last;
    logic [5:0]         output_index;
    logic signed [31:0] OUTPUT_DATA;
    logic signed [31:0] in_data [0:7][0:7];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int val;
        int idx;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    beat_t itm;
    int    acc_cnt = 0;
    bit    m_acc;
    bit    m_beat;

    int scan_order [0:63] = '{
        0, 1, 8, 9, 2, 3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
        4, 5, 12, 20, 13, 6, 7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
        32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
        51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    always #5 CLOCK = ~CLOCK;

    block_scan_serializer #(.BUF_BLOCKS(2)) dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .INPUT_DATA   (in_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .OUTPUT_DATA  (OUTPUT_DATA),
        .output_index (output_index),
        .output_last  (output_last)
    );

    function automatic int sat_ref(int v);
`ifdef SCAN_SAT16_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
`endif
        return v;
    endfunction

    function automatic int stored_blocks();
        return (exp_q.size() + 63) / 64;
    endfunction

    function automatic int raster_val(int ras);
        return int'(in_data[3'(ras / 8)][3'(ras % 8)]);
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(int base);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                in_data[3'(r)][3'(c)] = base + r * 8 + c;
    endtask

    task automatic fill_random();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                in_data[3'(r)][3'(c)] = $urandom();
    endtask

    task automatic wait_idle(string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge CLOCK);
            if (!output_valid && exp_q.size() == 0) break;
        end
        chk(name, int'(output_valid), 0);
    endtask

    task automatic wait_index(int idx, string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge CLOCK);
            if (output_valid && int'(output_index) == idx) break;
        end
        chk(name, int'(output_valid && int'(output_index) == idx), 1);
    endtask

    task automatic wait_last(string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge CLOCK);
            if (output_valid && output_last) break;
        end
        chk(name, int'(output_valid && output_last), 1);
    endtask

    // Reference model: each accepted block expands into its 64 expected beats
    always @(posedge CLOCK) begin
        if (!RESET) begin
            exp_q.delete();
        end else begin
            m_acc  = input_valid && (stored_blocks() < 2);
            m_beat = (exp_q.size() > 0) && output_ready;
            if (m_beat) void'(exp_q.pop_front());
            if (m_acc) begin
                acc_cnt++;
                for (int k = 0; k < 64; k++) begin
                    itm.val  = sat_ref(raster_val(scan_order[6'(k)]));
                    itm.idx  = k;
                    itm.last = (k == 63);
                    exp_q.push_back(itm);
                end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model
    always @(negedge CLOCK) begin
        chk("m_input_ready", int'(input_ready), int'(stored_blocks() < 2));
        chk("m_output_valid", int'(output_valid), int'(exp_q.size() > 0));
        if (output_valid && exp_q.size() > 0) begin
            chk("m_data", int'(OUTPUT_DATA), exp_q[0].val);
            chk("m_index", int'(output_index), exp_q[0].idx);
            chk("m_last", int'(output_last), int'(exp_q[0].last));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        fill(0);
        repeat (2) @(negedge CLOCK);
        chk("rst_valid", int'(output_valid), 0);
        chk("rst_data", int'(OUTPUT_DATA), 0);
        chk("rst_index", int'(output_index), 0);
        chk("rst_last", int'(output_last), 0);
        chk("rst_ready", int'(input_ready), 1);
        RESET = 1'b1;

        // Ramp block at full rate
        fill(0);
        input_valid = 1'b1;
        @(negedge CLOCK);
        input_valid = 1'b0;
        chk("a_first_valid", int'(output_valid), 1);
        chk("a_first_data", int'(OUTPUT_DATA), 0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!output_valid) break;
            n++;
            if (n == 3) chk("a_beat3_data", int'(OUTPUT_DATA), 8);
            if (n == 64) chk("a_last", int'(output_last), 1);
            @(negedge CLOCK);
        end
        chk("a_beats", n, 64);

        // Backpressure at index 10
        fill(0);
        input_valid = 1'b1;
        @(negedge CLOCK);
        input_valid = 1'b0;
        wait_index(10, "b_reach10");
        output_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK);
            chk("b_hold_data", int'(OUTPUT_DATA), 24);
            chk("b_hold_index", int'(output_index), 10);
        end
        output_ready = 1'b1;
        @(negedge CLOCK);
        chk("b_resume_data", int'(OUTPUT_DATA), 25);
        wait_idle("b_idle");

        // Three blocks offered back-to-back
        fill(1000);
        input_valid = 1'b1;
        @(negedge CLOCK);
        fill(2000);
        @(negedge CLOCK);
        fill(3000);
        chk("c_ready_full", int'(input_ready), 0);
        wait_last("c_reach_last");
        chk("c_ready_at_last", int'(input_ready), 0);
        chk("c_last_data", int'(OUTPUT_DATA), 1063);
        @(negedge CLOCK);
        chk("c_b2_valid", int'(output_valid), 1);
        chk("c_b2_index", int'(output_index), 0);
        chk("c_b2_data", int'(OUTPUT_DATA), 2000);
        chk("c_ready_after", int'(input_ready), 1);
        @(negedge CLOCK);
        input_valid = 1'b0;
        wait_idle("c_idle");

        // Accept on the same edge as the position-63 beat
        fill(4000);
        input_valid = 1'b1;
        @(negedge CLOCK);
        input_valid = 1'b0;
        wait_last("d_reach_last");
        fill(5000);
        input_valid = 1'b1;
        chk("d_ready_before", int'(input_ready), 1);
        @(negedge CLOCK);
        input_valid = 1'b0;
        chk("d_valid", int'(output_valid), 1);
        chk("d_index", int'(output_index), 0);
        chk("d_data", int'(OUTPUT_DATA), 5000);
        chk("d_ready_after", int'(input_ready), 1);
        wait_idle("d_idle");

        // Asynchronous reset mid-stream
        fill(0);
        input_valid = 1'b1;
        @(negedge CLOCK);
        input_valid = 1'b0;
        wait_index(30, "e_reach30");
        #1;
        RESET = 1'b0;
        exp_q.delete();
        #1;
        chk("e_rst_valid", int'(output_valid), 0);
        chk("e_rst_data", int'(OUTPUT_DATA), 0);
        chk("e_rst_index", int'(output_index), 0);
        chk("e_rst_last", int'(output_last), 0);
        chk("e_rst_ready", int'(input_ready), 1);
        @(negedge CLOCK);
        RESET = 1'b1;
        fill(500);
        input_valid = 1'b1;
        @(negedge CLOCK);
        input_valid = 1'b0;
        chk("e_restart_valid", int'(output_valid), 1);
        chk("e_restart_index", int'(output_index), 0);
        chk("e_restart_data", int'(OUTPUT_DATA), 500);
        wait_idle("e_idle");

        // Out-of-range coefficients
        fill_random();
        in_data[0][0] = 100000;
        in_data[0][1] = -100000;
        input_valid = 1'b1;
        @(negedge CLOCK);
        input_valid = 1'b0;
`ifdef SCAN_SAT16_EN
        chk("f_pos_data", int'(OUTPUT_DATA), 32767);
        @(negedge CLOCK);
        chk("f_neg_data", int'(OUTPUT_DATA), -32768);
`else
        chk("f_pos_data", int'(OUTPUT_DATA), 100000);
        @(negedge CLOCK);
        chk("f_neg_data", int'(OUTPUT_DATA), -100000);
`endif
        wait_idle("f_idle");

        // Randomized traffic with random backpressure
        for (int i = 0; i < 1500; i++) begin
            input_valid  = ($urandom_range(0, 2) == 0);
            output_ready = ($urandom_range(0, 3) != 0);
            if (input_valid) fill_random();
            @(negedge CLOCK);
        end
        input_valid  = 1'b0;
        output_ready = 1'b1;
        wait_idle("g_idle");
        chk("g_some_accepts", int'(acc_cnt > 20), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_scan_serializer.md
BLOCK_SCAN_SERIALIZER -- requirements
Module: block_scan_serializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be named CLOCK and RESET.
REQ-002 The block SHALL provide parameter BUF_BLOCKS, default 2: number of buffered 8x8 blocks; legal values 1 or 2.
REQ-003 The block SHALL provide port CLOCK, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL provide port RESET, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL provide port input_valid, input, 1 bit: INPUT_DATA holds a quantized block.
REQ-006 The block SHALL provide port input_ready, output, 1 bit: block buffer can accept a block.
REQ-007 The block SHALL provide port INPUT_DATA, input, signed 32 x [8][8]: quantized coefficients, [row][col].
REQ-008 The block SHALL provide port output_valid, output, 1 bit: OUTPUT_DATA is valid.
REQ-009 The block SHALL provide port output_ready, input, 1 bit: downstream accepts the current coefficient.
REQ-010 The block SHALL provide port OUTPUT_DATA, output, signed 32: current coefficient.
REQ-011 The block SHALL provide port output_index, output, 6 bits: scan position, 0..63.
REQ-012 The block SHALL provide port output_last, output, 1 bit: high with scan position 63.

Function
REQ-013 A block SHALL be accepted on a rising edge with input_valid=1 and input_ready=1; all 64 values are captured on that edge.
REQ-014 input_ready SHALL be 1 when the stored-block count is below BUF_BLOCKS; it is decoded from registers only and never depends on output_ready in the same cycle.
REQ-015 An accepted block SHALL be emitted as 64 coefficients in progressive scan order; raster index = row*8+col: 0,1,8,9,2,3,10,11,16,17,24,25,18,19,26,27,4,5,12,20,13,6,7,14,21,28,29,22,15,23,30,31,32,33,40,48,41,34,35,42,49,56,57,50,43,36,37,44,51,58,59,52,45,38,39,46,53,60,61,54,47,55,62,63.
REQ-016 The state machine SHALL have two states. EMPTY: output_valid=0. STREAM: output_valid=1. EMPTY->STREAM on block accept. STREAM->EMPTY on the accepted position-63 beat when no other block is stored.
REQ-017 Latency SHALL be 1 cycle: when the block is in EMPTY, the first coefficient is valid on the edge after the accept.
REQ-018 A beat SHALL complete when output_valid=1 and output_ready=1; output_index then advances by 1, and from 63 it wraps to 0.
REQ-019 While output_valid=1 and output_ready=0, OUTPUT_DATA, output_index and output_last SHALL hold stable.
REQ-020 When another block is stored at the position-63 beat, position 0 of that block SHALL follow on the next cycle with no bubble.
REQ-021 A block accept and a position-63 beat on the same edge SHALL both take effect; the stored-block count is unchanged.
REQ-022 input_valid while input_ready=0 SHALL be ignored, and no data is captured.

Reset
REQ-023 On RESET=0, asynchronously: output_valid=0, OUTPUT_DATA=0, output_index=0, output_last=0, input_ready=1, stored-block count=0, state=EMPTY.
REQ-024 Reset mid-stream SHALL discard all stored blocks; the first block accepted after reset starts at position 0.

Configuration
REQ-025 With SCAN_SAT16_EN defined, OUTPUT_DATA SHALL be the coefficient saturated to [-32768, 32767] and sign-extended to 32 bits.
REQ-026 Without SCAN_SAT16_EN, OUTPUT_DATA SHALL equal the stored 32-bit coefficient unchanged.

Verification
REQ-027 Stimulus: INPUT_DATA[r][c]=r*8+c, output_ready=1. Response: 64 beats carrying values in REQ-015 order, starting 1 cycle after accept; output_last only on the 64th beat; then output_valid=0.
REQ-028 Stimulus: same block, output_ready=0 for 5 cycles when output_index=10. Response: OUTPUT_DATA=24 and output_index=10 held for all 5 cycles; stream resumes with 25.
REQ-029 Stimulus: BUF_BLOCKS=2, three blocks offered back-to-back. Response: two blocks accepted; input_ready=0 until the first block's position-63 beat; block 2 position 0 immediately follows block 1 position 63.
REQ-030 Stimulus: RESET=0 mid-cycle at output_index=30. Response: all outputs zero immediately, input_ready=1; the next block restarts at index 0 with value from raster 0.
REQ-031 Stimulus: raster 0 = 100000, raster 1 = -100000. Response with SCAN_SAT16_EN: 32767, -32768. Response without SCAN_SAT16_EN: 100000, -100000.
REQ-032 Stimulus: block accept on the same edge as the position-63 beat, with one block stored. Response: count unchanged, no bubble, input_ready stays 1 (BUF_BLOCKS=2).
